// File: rtl/basys3_pkg.sv
// Board-level constants and helpers shared by the Basys3 logic.
// The clock/reset generator supplies a 100 MHz domain. Blocks in that domain
// derive their cycle counts from wall-clock time through ms_to_cycles().
package basys3_pkg;

  // Frequency of the system clock, in Hz.
  localparam int CLK_100M00_HZ = 32'sd100_000_000;

  // Number of system clock cycles in one millisecond.
  localparam int CYCLES_PER_MS = CLK_100M00_HZ / 32'sd1000;

  // Converts a duration in milliseconds into a number of 100 MHz cycles.
  function automatic int ms_to_cycles(input int ms);
    return CYCLES_PER_MS * ms;
  endfunction

  // Direction of a debounced level change on one channel.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

endpackage

// File: rtl/debounce_cell.sv
// One pushbutton channel.
// The raw input passes through a synchroniser chain. A counter then measures
// how long the synchronised value has disagreed with the debounced level.
// The level follows the input only after DEBOUNCE_CYCLES consecutive
// disagreeing cycles. A one-cycle press or release strobe marks each change.
module debounce_cell
  import basys3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, because the terminal
  // count always clears it. For that reason it can never wrap.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'sd0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;

  logic                   w_sync;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_level_nxt;
  edge_e                  w_edge;
  logic                   w_press_nxt;
  logic                   w_release_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Shift the asynchronous button through the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  // Count cycles of disagreement and decide whether the level flips now.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_edge      = EDGE_NONE;
    if (w_sync == r_level) begin
      // Any return to the current level throws away accumulated progress.
      w_cnt_nxt = CNT_ZERO;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_nxt   = CNT_ZERO;
      w_level_nxt = ~r_level;
      w_edge      = r_level ? EDGE_FALL : EDGE_RISE;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  // Turn the detected level change into press/release strobe requests.
  always_comb begin
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (w_edge)
      EDGE_RISE: begin
        w_press_nxt   = 1'b1;
        w_release_nxt = 1'b0;
      end
      EDGE_FALL: begin
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b1;
      end
      default: begin
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
      end
    endcase
  end

  // Hold the disagreement counter and the debounced level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= CNT_ZERO;
      r_level <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Register the one-cycle strobes. Reset clears them without emitting one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_debounce.sv
// Debounces the Basys3 pushbuttons in the 100 MHz domain.
// Each button has its own independent debounce_cell. Cells share no state,
// so events on several channels produce simultaneous, independent strobes.
module button_debounce
  import basys3_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(32'sd10),
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk_100m00,
  input  logic               rst_100m00_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_cell (
      .i_clk     (clk_100m00),
      .i_rst_n   (rst_100m00_n),
      .i_btn     (btn_in[gi]),
      .o_level   (w_level[gi]),
      .o_press   (w_press[gi]),
      .o_release (w_release[gi])
    );
  end

  // Every output below comes straight from a flop inside its cell.
  assign btn_level   = w_level;
  assign btn_press   = w_press;
  assign btn_release = w_release;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with NUM_BTN=5, DEBOUNCE_CYCLES=16
// and SYNC_STAGES=2.
// The reference model keeps the recent input samples of each channel.
// A channel's level flips once the last DEBOUNCE_CYCLES synchronised samples
// all disagree with it.
module tb_button_debounce;

  localparam int NB   = 5;
  localparam int DEB  = 16;
  localparam int SS   = 2;
  localparam int HLEN = SS - 1 + DEB;
  localparam int LAT  = SS + DEB - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic [NB-1:0] dut_level, dut_press, dut_release;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NB-1:0]   m_level, m_press, m_release;
  logic [HLEN-1:0] m_hist [NB];

  always #5 clk = ~clk;

  button_debounce #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SS)
  ) dut (
    .clk_100m00   (clk),
    .rst_100m00_n (rst_n),
    .btn_in       (btn),
    .btn_level    (dut_level),
    .btn_press    (dut_press),
    .btn_release  (dut_release)
  );

  // Bit 0 of h is the sample from the previous edge.
  // The window seen after the synchroniser is bits SS-1 .. HLEN-1.
  function automatic logic window_disagrees(input logic [HLEN-1:0] h, input logic lvl);
    logic [DEB-1:0] w;
    w = h[HLEN-1:SS-1];
    return lvl ? (w == {DEB{1'b0}}) : (&w);
  endfunction

  // Reference model: a sample history per channel plus the expected outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) m_hist[i] <= {HLEN{1'b0}};
      m_level   <= {NB{1'b0}};
      m_press   <= {NB{1'b0}};
      m_release <= {NB{1'b0}};
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (window_disagrees(m_hist[i], m_level[i])) begin
          m_level[i]   <= ~m_level[i];
          m_press[i]   <= ~m_level[i];
          m_release[i] <= m_level[i];
        end else begin
          m_press[i]   <= 1'b0;
          m_release[i] <= 1'b0;
        end
        m_hist[i] <= {m_hist[i][HLEN-2:0], btn[i]};
      end
    end
  end

  // Hold reset for a couple of cycles with the given inputs.
  // Return at the falling edge where reset is released.
  task automatic do_reset(input logic [NB-1:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    btn   = v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int lat, np;
    logic [NB-1:0] pv;
    @(negedge clk);
    rst_n = 1'b0;
    btn   = {NB{1'b1}};
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {(3*NB){1'b0}}) begin
        n_fail++;
        $display("FAIL reset_hold got=%h exp=%h", {dut_level, dut_press, dut_release}, {(3*NB){1'b0}});
      end
    end
    rst_n = 1'b1;
    lat = -1; np = 0; pv = {NB{1'b0}};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL reset_model c=%0d got=%h exp=%h", c, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_press != {NB{1'b0}}) begin
        np++;
        pv = dut_press;
        if (lat < 0) lat = c;
      end
    end
    n_tests++;
    if (np != 1 || pv !== 5'b11111 || lat < LAT - 1 || lat > LAT + 1) begin
      n_fail++;
      $display("FAIL reset_held_press got n=%0d vec=%b lat=%0d exp n=1 vec=11111 lat=%0d", np, pv, lat, LAT);
    end
    n_tests++;
    if (dut_level !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_held_level got=%b exp=11111", dut_level);
    end
  endtask

  task automatic test_press_release();
    int lat_p, lat_r, np, nr;
    logic [NB-1:0] others;
    do_reset({NB{1'b0}});
    btn[2] = 1'b1;
    lat_p = -1; np = 0; others = {NB{1'b0}};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL press_model c=%0d got=%h exp=%h", c, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_press[2]) begin np++; if (lat_p < 0) lat_p = c; end
      others |= (dut_level | dut_press | dut_release) & 5'b11011;
    end
    n_tests++;
    if (np != 1 || lat_p < LAT - 1 || lat_p > LAT + 1 || dut_level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL press2 got n=%0d lat=%0d lvl=%b exp n=1 lat=%0d lvl=1", np, lat_p, dut_level[2], LAT);
    end
    btn[2] = 1'b0;
    lat_r = -1; nr = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL release_model c=%0d got=%h exp=%h", c, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_release[2]) begin nr++; if (lat_r < 0) lat_r = c; end
      others |= (dut_level | dut_press | dut_release) & 5'b11011;
    end
    n_tests++;
    if (nr != 1 || lat_r < LAT - 1 || lat_r > LAT + 1 || dut_level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL release2 got n=%0d lat=%0d lvl=%b exp n=1 lat=%0d lvl=0", nr, lat_r, dut_level[2], LAT);
    end
    n_tests++;
    if (others !== {NB{1'b0}}) begin
      n_fail++;
      $display("FAIL press_others got=%b exp=00000", others);
    end
  endtask

  task automatic test_bounce();
    int nb, np, lat;
    do_reset({NB{1'b0}});
    nb = 0;
    for (int t = 0; t < 100; t++) begin
      btn[0] = ((t / 5) % 2 == 0);
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL bounce_model t=%0d got=%h exp=%h", t, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_press[0] || dut_release[0] || dut_level[0]) nb++;
    end
    n_tests++;
    if (nb != 0) begin
      n_fail++;
      $display("FAIL bounce_quiet got=%0d events exp=0", nb);
    end
    btn[0] = 1'b1;
    np = 0; lat = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL bounce_settle_model c=%0d got=%h exp=%h", c, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_press[0]) begin np++; if (lat < 0) lat = c; end
    end
    n_tests++;
    if (np != 1 || lat < LAT - 1 || lat > LAT + 1) begin
      n_fail++;
      $display("FAIL bounce_press got n=%0d lat=%0d exp n=1 lat=%0d", np, lat, LAT);
    end
  endtask

  task automatic test_glitch();
    int np, nr, tp, tr, cyc, nlev;
    do_reset({NB{1'b0}});
    for (int pass = 0; pass < 2; pass++) begin
      np = 0; nr = 0; tp = -1; tr = -1; cyc = 0; nlev = 0;
      for (int t = 0; t < 60 + (pass == 0 ? 15 : 20); t++) begin
        btn[4] = (t < (pass == 0 ? 15 : 20));
        @(negedge clk);
        cyc++;
        n_tests++;
        if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
          n_fail++;
          $display("FAIL glitch_model pass=%0d t=%0d got=%h exp=%h", pass, t, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
        end
        if (dut_press[4])   begin np++; if (tp < 0) tp = cyc; end
        if (dut_release[4]) begin nr++; if (tr < 0) tr = cyc; end
        if (dut_level[4]) nlev++;
      end
      n_tests++;
      if (pass == 0) begin
        if (np != 0 || nr != 0 || nlev != 0) begin
          n_fail++;
          $display("FAIL glitch15 got press=%0d rel=%0d lvl_cycles=%0d exp 0 0 0", np, nr, nlev);
        end
      end else begin
        if (np != 1 || nr != 1 || tp >= tr) begin
          n_fail++;
          $display("FAIL glitch20 got press=%0d@%0d rel=%0d@%0d exp one press then one release", np, tp, nr, tr);
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    int np_pre, np, lat;
    do_reset({NB{1'b0}});
    btn[1] = 1'b1;
    np_pre = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL midcount_model c=%0d got=%h exp=%h", c, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_press[1]) np_pre++;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dut_level, dut_press, dut_release} !== {(3*NB){1'b0}} || np_pre != 0) begin
      n_fail++;
      $display("FAIL midcount_reset got=%h pre_press=%0d exp=0 0", {dut_level, dut_press, dut_release}, np_pre);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    np = 0; lat = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL midcount_after_model c=%0d got=%h exp=%h", c, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_press[1]) begin np++; if (lat < 0) lat = c; end
    end
    n_tests++;
    if (np != 1 || lat < LAT - 1 || lat > LAT + 1) begin
      n_fail++;
      $display("FAIL midcount_press got n=%0d lat=%0d exp n=1 lat=%0d", np, lat, LAT);
    end
  endtask

  task automatic test_simultaneous();
    int t1, t3;
    do_reset({NB{1'b0}});
    btn = 5'b01010;
    t1 = -1; t3 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL simul_model c=%0d got=%h exp=%h", c, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      if (dut_press[1] && t1 < 0) t1 = c;
      if (dut_press[3] && t3 < 0) t3 = c;
    end
    n_tests++;
    if (t1 < 0 || t1 != t3 || t1 < LAT - 1 || t1 > LAT + 1) begin
      n_fail++;
      $display("FAIL simul_press got t1=%0d t3=%0d exp both=%0d", t1, t3, LAT);
    end
  endtask

  task automatic test_random();
    int hold [NB];
    do_reset({NB{1'b0}});
    for (int i = 0; i < NB; i++) hold[i] = $urandom_range(1, 40);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          btn[i]  = ~btn[i];
          hold[i] = $urandom_range(1, 40);
        end else begin
          hold[i]--;
        end
      end
      @(negedge clk);
      n_tests++;
      if ({dut_level, dut_press, dut_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, {dut_level, dut_press, dut_release}, {m_level, m_press, m_release});
      end
      n_tests++;
      if ((dut_press & dut_release) !== {NB{1'b0}}) begin
        n_fail++;
        $display("FAIL random_both_strobes cyc=%0d got=%b exp=00000", cyc, dut_press & dut_release);
      end
    end
  endtask

  // Bound the whole run even if a task were to stall.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    btn   = {NB{1'b0}};
    test_reset();
    test_press_release();
    test_bounce();
    test_glitch();
    test_reset_midcount();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
